// File: rtl/cc_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, its sample source, the ranking core and the result sink.
interface cc_frame_sequencer_if;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned OPT_W   = 3;
    localparam int unsigned A_W     = 2;
    localparam int unsigned B_W     = 3;

    logic               in_valid;
    logic [SCORE_W-1:0] in_score;
    logic [OPT_W-1:0]   in_opt;
    logic [A_W-1:0]     in_a;
    logic [B_W-1:0]     in_b;
    logic               in_ready;

    logic [SCORE_W-1:0] core_s0, core_s1, core_s2, core_s3, core_s4, core_s5, core_s6;
    logic [OPT_W-1:0]   core_opt;
    logic [A_W-1:0]     core_a;
    logic [B_W-1:0]     core_b;

    logic [ID_W-1:0]    core_id0, core_id1, core_id2, core_id3, core_id4, core_id5, core_id6;
    logic [ID_W-1:0]    core_out;

    logic               out_valid;
    logic [ID_W-1:0]    out_id;
    logic [ID_W-1:0]    out_result;

    // Sequencer side
    modport slave (
        input  in_valid, in_score, in_opt, in_a, in_b,
        input  core_id0, core_id1, core_id2, core_id3, core_id4, core_id5, core_id6, core_out,
        output in_ready,
        output core_s0, core_s1, core_s2, core_s3, core_s4, core_s5, core_s6,
        output core_opt, core_a, core_b,
        output out_valid, out_id, out_result
    );

    // Environment side: sample source, core and result sink
    modport master (
        output in_valid, in_score, in_opt, in_a, in_b,
        output core_id0, core_id1, core_id2, core_id3, core_id4, core_id5, core_id6, core_out,
        input  in_ready,
        input  core_s0, core_s1, core_s2, core_s3, core_s4, core_s5, core_s6,
        input  core_opt, core_a, core_b,
        input  out_valid, out_id, out_result
    );
endinterface

// File: rtl/cc_frame_sequencer.sv
// Serial-to-parallel loader in front of the class-ranking core and parallel-to-serial
// result streamer behind it: 7 samples in, one CALC cycle, 7 ranked IDs out.
module cc_frame_sequencer (
    input  logic                 clk,
    input  logic                 rst_n,
    cc_frame_sequencer_if.slave  bus
);
    localparam int unsigned NUM_STU = 7;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned OPT_W   = 3;
    localparam int unsigned A_W     = 2;
    localparam int unsigned B_W     = 3;
    localparam int unsigned CNT_W   = 3;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_STU - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_e;

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [NUM_STU-1:0][SCORE_W-1:0]   score_q, score_d;
    logic [OPT_W-1:0]                  opt_q, opt_d;
    logic [A_W-1:0]                    a_q, a_d;
    logic [B_W-1:0]                    b_q, b_d;
    logic [NUM_STU-1:0][ID_W-1:0]      res_id_q, res_id_d;
    logic [ID_W-1:0]                   res_q, res_d;
    logic                              in_ready_q, in_ready_d;
    logic                              out_valid_q, out_valid_d;
    logic [ID_W-1:0]                   out_id_q, out_id_d;
    logic [ID_W-1:0]                   out_result_q, out_result_d;
    logic [NUM_STU-1:0][ID_W-1:0]      core_ids;

    assign core_ids = {bus.core_id6, bus.core_id5, bus.core_id4, bus.core_id3,
                       bus.core_id2, bus.core_id1, bus.core_id0};

    // Next-state, bank writes and registered output stream
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_d      = score_q;
        opt_d        = opt_q;
        a_d          = a_q;
        b_d          = b_q;
        res_id_d     = res_id_q;
        res_d        = res_q;
        out_valid_d  = 1'b0;
        out_id_d     = '0;
        out_result_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    score_d[0] = bus.in_score;
                    opt_d      = bus.in_opt;
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    cnt_d      = CNT_W'(1);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    score_d[cnt_q] = bus.in_score;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // A gap mid-frame drops the frame entirely
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CALC: begin
                // The first output beat is taken straight from the core as it is captured
                res_id_d     = core_ids;
                res_d        = bus.core_out;
                cnt_d        = '0;
                state_d      = OUT;
                out_valid_d  = 1'b1;
                out_id_d     = core_ids[0];
                out_result_d = bus.core_out;
            end
            OUT: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    out_valid_d  = 1'b1;
                    out_id_d     = res_id_q[cnt_d];
                    out_result_d = res_q;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            score_q      <= '0;
            opt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_id_q     <= '0;
            res_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            opt_q        <= opt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_id_q     <= res_id_d;
            res_q        <= res_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_result_q <= out_result_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.core_s0    = score_q[0];
    assign bus.core_s1    = score_q[1];
    assign bus.core_s2    = score_q[2];
    assign bus.core_s3    = score_q[3];
    assign bus.core_s4    = score_q[4];
    assign bus.core_s5    = score_q[5];
    assign bus.core_s6    = score_q[6];
    assign bus.core_opt   = opt_q;
    assign bus.core_a     = a_q;
    assign bus.core_b     = b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_result = out_result_q;
endmodule

// File: tb/tb_cc_frame_sequencer.sv
// Bench for cc_frame_sequencer: stand-in ranking core, frame-level timeline model with
// per-cycle expectations, directed cases followed by random frames, gaps and aborts.
module tb_cc_frame_sequencer;
    localparam int NCYC = 2000;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    cc_frame_sequencer_if bus ();

    cc_frame_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: stable ascending sort by score; pass = score >= 3+a, inverted by opt[2]
    function automatic void rank(input logic [6:0][3:0] s, input logic [2:0] o, input logic [1:0] a,
                                 output logic [6:0][2:0] ids, output logic [2:0] res);
        int pos;
        int n;
        n   = 0;
        ids = '0;
        for (int i = 0; i < 7; i++) begin
            pos = 0;
            for (int j = 0; j < 7; j++)
                if (s[j] < s[i] || (s[j] == s[i] && j < i)) pos++;
            ids[pos] = 3'(i);
            if (int'(s[i]) >= 3 + int'(a)) n++;
        end
        if (o[2]) n = 7 - n;
        res = 3'(n);
    endfunction

    logic [6:0][3:0] core_sv;
    logic [6:0][2:0] core_idv;
    logic [2:0]      core_res;
    assign core_sv = {bus.core_s6, bus.core_s5, bus.core_s4, bus.core_s3,
                      bus.core_s2, bus.core_s1, bus.core_s0};
    always_comb rank(core_sv, bus.core_opt, bus.core_a, core_idv, core_res);
    assign bus.core_id0 = core_idv[0];
    assign bus.core_id1 = core_idv[1];
    assign bus.core_id2 = core_idv[2];
    assign bus.core_id3 = core_idv[3];
    assign bus.core_id4 = core_idv[4];
    assign bus.core_id5 = core_idv[5];
    assign bus.core_id6 = core_idv[6];
    assign bus.core_out = core_res;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle expectations, filled in by the stimulus model
    bit              exp_valid [NCYC];
    logic [2:0]      exp_id    [NCYC];
    logic [2:0]      exp_res   [NCYC];
    bit              exp_ready [NCYC];
    bit              exp_core  [NCYC];
    int              busy_end = 0;
    int              k = 0;
    logic [6:0][3:0] fr, last_fr;
    logic [2:0]      fo, last_o;
    logic [1:0]      fa, last_a;
    logic [2:0]      fb, last_b;

    task automatic check_core(input string pfx);
        chk({pfx, "core_s0"}, bus.core_s0, last_fr[0]);
        chk({pfx, "core_s1"}, bus.core_s1, last_fr[1]);
        chk({pfx, "core_s2"}, bus.core_s2, last_fr[2]);
        chk({pfx, "core_s3"}, bus.core_s3, last_fr[3]);
        chk({pfx, "core_s4"}, bus.core_s4, last_fr[4]);
        chk({pfx, "core_s5"}, bus.core_s5, last_fr[5]);
        chk({pfx, "core_s6"}, bus.core_s6, last_fr[6]);
        chk({pfx, "core_opt"}, bus.core_opt, last_o);
        chk({pfx, "core_a"}, bus.core_a, last_a);
        chk({pfx, "core_b"}, bus.core_b, last_b);
    endtask

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            chk($sformatf("out_valid@%0d", cyc), bus.out_valid, exp_valid[cyc]);
            chk($sformatf("out_id@%0d", cyc), bus.out_id, exp_valid[cyc] ? exp_id[cyc] : 3'd0);
            chk($sformatf("out_result@%0d", cyc), bus.out_result, exp_valid[cyc] ? exp_res[cyc] : 3'd0);
            chk($sformatf("in_ready@%0d", cyc), bus.in_ready, exp_ready[cyc]);
            if (exp_core[cyc]) check_core($sformatf("@%0d ", cyc));
        end
    end

    // One input cycle; a frame is seven accepted samples with no gap, ready again 9 cycles after the last
    task automatic step(input bit v, input logic [3:0] s, input logic [2:0] o,
                        input logic [1:0] a, input logic [2:0] b);
        int c;
        logic [6:0][2:0] ids;
        logic [2:0] res;
        @(posedge clk);
        #1;
        c = cyc;
        bus.in_valid = v;
        bus.in_score = s;
        bus.in_opt   = o;
        bus.in_a     = a;
        bus.in_b     = b;
        if (c >= busy_end) begin
            if (v) begin
                if (k == 0) begin
                    fo = o; fa = a; fb = b;
                end
                fr[k] = s;
                k++;
                if (k == 7) begin
                    rank(fr, fo, fa, ids, res);
                    last_fr = fr; last_o = fo; last_a = fa; last_b = fb;
                    for (int i = 0; i < 7; i++) begin
                        exp_valid[c + 2 + i] = 1'b1;
                        exp_id[c + 2 + i]    = ids[i];
                        exp_res[c + 2 + i]   = res;
                    end
                    for (int i = 1; i <= 8; i++) begin
                        exp_ready[c + i] = 1'b0;
                        exp_core[c + i]  = 1'b1;
                    end
                    busy_end = c + 9;
                    k = 0;
                end
            end else begin
                k = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [6:0][3:0] s, input logic [2:0] o,
                              input logic [1:0] a, input logic [2:0] b);
        for (int i = 0; i < 7; i++) step(1'b1, s[i], o, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
    endtask

    logic [6:0][3:0] asc, five, desc;

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_valid[i] = 1'b0; exp_id[i] = '0; exp_res[i] = '0;
            exp_ready[i] = 1'b1; exp_core[i] = 1'b0;
        end
        last_fr = '0; last_o = '0; last_a = '0; last_b = '0;
        fr = '0; fo = '0; fa = '0; fb = '0;
        for (int i = 0; i < 7; i++) begin
            asc[i]  = 4'(i);
            five[i] = 4'd5;
            desc[i] = 4'(6 - i);
        end
        bus.in_valid = 1'b0; bus.in_score = '0; bus.in_opt = '0; bus.in_a = '0; bus.in_b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst out_valid", bus.out_valid, 0);
        check_core("rst ");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        idle(2);
        send_frame(asc, 3'd0, 2'd0, 3'd0);
        idle(10);
        send_frame(five, 3'b100, 2'd0, 3'd0);
        idle(10);
        for (int i = 0; i < 3; i++) step(1'b1, asc[i], 3'd5, 2'd1, 3'd7);
        idle(10);
        send_frame(asc, 3'd0, 2'd0, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 4'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
        idle(3);
        send_frame(asc, 3'd0, 2'd0, 3'd0);
        idle(8);
        send_frame(desc, 3'd0, 2'd0, 3'd0);
        idle(10);

        // Random frames, gaps, aborts and busy-time samples
        for (int n = 0; n < 600; n++) begin
            bit v;
            if (cyc + 1 < busy_end) v = ($urandom_range(0, 1) == 1);
            else if (k > 0)         v = ($urandom_range(0, 15) != 0);
            else                    v = ($urandom_range(0, 2) == 0);
            step(v, 4'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
        end
        idle(12);

        // Asynchronous reset in the third output beat
        send_frame(desc, 3'b100, 2'd1, 3'd3);
        idle(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = cyc; i < NCYC; i++) begin
            exp_valid[i] = 1'b0; exp_ready[i] = 1'b1; exp_core[i] = 1'b0;
        end
        last_fr = '0; last_o = '0; last_a = '0; last_b = '0;
        busy_end = 0;
        k = 0;
        chk("arst out_valid", bus.out_valid, 0);
        chk("arst out_id", bus.out_id, 0);
        chk("arst out_result", bus.out_result, 0);
        check_core("arst ");
        for (int i = cyc + 1; i < cyc + 6; i++) exp_core[i] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cc_frame_sequencer.md
# cc_frame_sequencer

Sequential front/back end for the combinational class-ranking core. Collects one frame of seven 4-bit student scores serially plus the per-frame option fields, and holds them in registers that drive the core's parallel inputs. It then captures the core's seven sorted IDs and pass-count result and streams them out serially under a valid strobe. The core itself is instantiated outside this block; this block sits directly upstream of its inputs and downstream of its outputs.

## Interface
- No parameters. Frame length is fixed at 7 students; score width 4, ID/result width 3.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  score sample valid this cycle.
- in_score  in  4  score of student n (n = 0..6, in arrival order).
- in_opt  in  3  option field, sampled only with the first sample of a frame.
- in_a  in  2  parameter a, sampled with the first sample.
- in_b  in  3  parameter b, sampled with the first sample.
- in_ready  out  1  block can accept samples (IDLE or LOAD).
- core_s0..core_s6  out  4 each  registered scores to the core.
- core_opt / core_a / core_b  out  3/2/3  registered options to the core.
- core_id0..core_id6  in  3 each  sorted IDs from the core (combinational).
- core_out  in  3  pass-count result from the core.
- out_valid  out  1  result stream valid.
- out_id  out  3  sorted ID stream, core_id0 first.
- out_result  out  3  core_out value, held on every out_valid cycle.

## Operation
- States: IDLE, LOAD, CALC, OUT. A 3-bit counter cnt indexes samples in LOAD and outputs in OUT.
- IDLE: when in_valid=1, write in_score to core_s0 and latch in_opt/in_a/in_b. Set cnt=1 and go to LOAD.
- LOAD: when in_valid=1, write in_score to core_s[cnt] and increment cnt. The sample at cnt=6 completes the frame; go to CALC.
- LOAD abort: if in_valid=0 in LOAD, discard the frame and return to IDLE with cnt=0.
  - Partially written bank contents are don't-care.
  - No out_valid is produced for the aborted frame.
- CALC: one cycle. Core inputs are stable. At the end of the cycle, register core_id0..6 and core_out into result registers. Go to OUT with cnt=0.
- OUT: out_valid=1, out_id = result_id[cnt], out_result = result value. Increment cnt; after cnt=6, go to IDLE.
- in_valid during CALC/OUT is ignored (in_ready=0).
- core_* outputs hold their values from the last load until overwritten by the next frame; they are never cleared except by reset.
- Outside OUT: out_valid=0, out_id=0, out_result=0.
- Reset (asynchronous, any state, including mid-LOAD and mid-OUT):
  - State returns to IDLE, cnt=0.
  - All core_* outputs, result registers, out_valid, out_id and out_result are cleared to 0.
  - in_ready=1 after reset release.

## Timing
- Frame input is 7 consecutive in_valid cycles, cycles T..T+6. Options are sampled at T only.
- CALC occupies cycle T+7. out_valid is high for cycles T+8..T+14, exactly 7 consecutive cycles.
- Latency: first out_valid arrives 2 cycles after the last in_valid cycle.
- in_ready=1 in cycles ≤T+6, 0 in T+7..T+14, and 1 again from T+15.
  - A new frame may start at T+15.
  - Back-to-back throughput is 1 frame per 15 cycles.
- in_ready and out_valid are registered state decodes with no combinational path from in_valid.
- Combinational path into this block: core_id*/core_out to the result registers only, captured one full cycle after core inputs settle.

## Test plan
- Scores 0,1,2,3,4,5,6, opt=0, a=0, b=0 → out_valid 7 cycles starting 2 cycles after the last in_valid; out_id 0,1,2,3,4,5,6; out_result=4 on every cycle.
- All scores 5, opt=3'b100, a=0, b=0 → out_id 0..6 (ties resolved by ID); out_result=0 (all 7 pass, inverted).
- in_valid high for 3 cycles then low → no out_valid ever; in_ready stays 1. A subsequent full frame with the first test's stimulus produces the first test's output exactly.
- in_valid held high through CALC/OUT after a frame → extra samples ignored; core_s* unchanged until in_ready returns; one 7-cycle output burst only.
- Assert rst_n=0 mid-OUT (3rd output cycle) → out_valid, out_id, out_result and all core_* go to 0 immediately (asynchronously); in_ready=1 after release; no further outputs.
- Two back-to-back frames, second starting at T+15 with scores 6,5,4,3,2,1,0, opt=0, a=0, b=0 → second burst out_id 6,5,4,3,2,1,0, out_result=4; no gap errors or overlap with the first burst.
